// File: rtl/ysyx_23060184_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_pipe_ctrl_pkg
// Purpose  : Shared definitions for the NPC pipeline stage-control unit.
//            Holds the fetch-drop FSM state encodings and state width.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060184_pipe_ctrl_pkg;

  localparam int PIPE_STATE_W = 1;

  // RUN  : fetch responses are consumed normally.
  // DROP : a redirect left a wrong-path fetch in flight; its response is
  //        discarded when it arrives.
  typedef enum logic [PIPE_STATE_W-1:0] {
    PIPE_STATE_RUN  = 1'b0,
    PIPE_STATE_DROP = 1'b1
  } pipe_state_e;

endpackage : ysyx_23060184_pipe_ctrl_pkg
`default_nettype wire

// File: rtl/ysyx_23060184_pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_SatCounter
// Purpose  : Enable-gated up-counter that saturates at all-ones.
// Ports    : clk   - clock
//            rstn  - asynchronous active-low reset (clears count)
//            en    - increment request for this cycle
//            count - current value
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_SatCounter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (en && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : ysyx_23060184_SatCounter
`default_nettype wire

// File: rtl/ysyx_23060184_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_pipe_ctrl
// Purpose  : Stage-control unit for the 5-stage NPC pipeline. Tracks a live
//            bit per stage and produces the stall/flush controls for the
//            IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering load-use
//            bubbles, redirect squash (including an in-flight fetch) and
//            multi-cycle memory stalls. Keeps stall/flush counters.
// Ports    : clk, rstn                - clock, async active-low reset
//            InstValidF, IfuBusy      - IFU response / outstanding request
//            Rs1D, Rs2D, RdE, MemReadE- hazard tags from ID and EX
//            BranchE                  - EX redirect
//            MemBusyM                 - LSU still busy in MEM
//            Stall*/Flush*/DropF      - combinational pipeline controls
//            Valid{D,E,M,W}           - per-stage live bits
//            StallCnt, FlushCnt       - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_pipe_ctrl
  import ysyx_23060184_pipe_ctrl_pkg::*;
#(
  parameter int REG_LENGTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  InstValidF,
  input  logic                  IfuBusy,
  input  logic [REG_LENGTH-1:0] Rs1D,
  input  logic [REG_LENGTH-1:0] Rs2D,
  input  logic [REG_LENGTH-1:0] RdE,
  input  logic                  MemReadE,
  input  logic                  BranchE,
  input  logic                  MemBusyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  DropF,
  output logic                  ValidD,
  output logic                  ValidE,
  output logic                  ValidM,
  output logic                  ValidW,
  output logic [CNT_WIDTH-1:0]  StallCnt,
  output logic [CNT_WIDTH-1:0]  FlushCnt
);

  pipe_state_e state, state_next;

  logic mem_stall;
  logic redirect;
  logic load_use;

  // Priority memStall > redirect > loadUse is encoded by masking the lower
  // events with the higher ones. A branch held in EX during a memory stall
  // is therefore taken on the first cycle the stall clears.
  always_comb begin
    mem_stall = MemBusyM & ValidM;
    redirect  = BranchE & ValidE & ~mem_stall;
    load_use  = MemReadE & ValidE & ValidD & (RdE != '0) &
                ((RdE == Rs1D) | (RdE == Rs2D)) & ~redirect & ~mem_stall;
  end

  always_comb begin
    StallF = mem_stall | load_use;
    StallD = mem_stall | load_use;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushD = redirect;
    FlushE = redirect | load_use;
    DropF  = (state == PIPE_STATE_DROP) & InstValidF;
  end

  // Next-state: a redirect that leaves a request outstanding with no
  // response yet must discard that response later. This also covers a
  // repeat redirect while already dropping.
  always_comb begin
    state_next = state;
    if (redirect && IfuBusy && !InstValidF) begin
      state_next = PIPE_STATE_DROP;
    end else if (state == PIPE_STATE_DROP && (InstValidF || !IfuBusy)) begin
      state_next = PIPE_STATE_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= PIPE_STATE_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ValidD <= 1'b0;
      ValidE <= 1'b0;
      ValidM <= 1'b0;
      ValidW <= 1'b0;
    end else if (mem_stall) begin
      // Everything up to MEM holds; WB receives a bubble.
      ValidW <= 1'b0;
    end else if (redirect) begin
      ValidD <= 1'b0;
      ValidE <= 1'b0;
      ValidM <= 1'b1;
      ValidW <= ValidM;
    end else if (load_use) begin
      // ID holds its instruction; a bubble enters EX behind the load.
      ValidE <= 1'b0;
      ValidM <= ValidE;
      ValidW <= ValidM;
    end else begin
      ValidD <= InstValidF & ~DropF;
      ValidE <= ValidD;
      ValidM <= ValidE;
      ValidW <= ValidM;
    end
  end

  ysyx_23060184_SatCounter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (StallF),
    .count (StallCnt)
  );

  ysyx_23060184_SatCounter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (redirect),
    .count (FlushCnt)
  );

endmodule : ysyx_23060184_pipe_ctrl
`default_nettype wire

// File: tb/tb_ysyx_23060184_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060184_pipe_ctrl
// Purpose  : Directed self-checking bench for ysyx_23060184_pipe_ctrl.
//            Uses a 4-bit counter width so saturation is reachable quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_pipe_ctrl;

  localparam int REG_LENGTH = 5;
  localparam int CNT_WIDTH  = 4;

  logic                  clk;
  logic                  rstn;
  logic                  InstValidF;
  logic                  IfuBusy;
  logic [REG_LENGTH-1:0] Rs1D;
  logic [REG_LENGTH-1:0] Rs2D;
  logic [REG_LENGTH-1:0] RdE;
  logic                  MemReadE;
  logic                  BranchE;
  logic                  MemBusyM;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, DropF;
  logic                  ValidD, ValidE, ValidM, ValidW;
  logic [CNT_WIDTH-1:0]  StallCnt;
  logic [CNT_WIDTH-1:0]  FlushCnt;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060184_pipe_ctrl #(
    .REG_LENGTH (REG_LENGTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .InstValidF (InstValidF),
    .IfuBusy    (IfuBusy),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .MemReadE   (MemReadE),
    .BranchE    (BranchE),
    .MemBusyM   (MemBusyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .DropF      (DropF),
    .ValidD     (ValidD),
    .ValidE     (ValidE),
    .ValidM     (ValidM),
    .ValidW     (ValidW),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,DropF}
  function automatic logic [6:0] ctrl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, DropF};
  endfunction

  // Valid vector order: {ValidD,ValidE,ValidM,ValidW}
  function automatic logic [3:0] valids();
    return {ValidD, ValidE, ValidM, ValidW};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then settle before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    InstValidF = 1'b0;
    IfuBusy    = 1'b0;
    Rs1D       = '0;
    Rs2D       = '0;
    RdE        = '0;
    MemReadE   = 1'b0;
    BranchE    = 1'b0;
    MemBusyM   = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;

    // Reset state
    #2;
    check("rst_valids",   32'(valids()),  32'h0);
    check("rst_ctrl",     32'(ctrl()),    32'h0);
    check("rst_stallcnt", 32'(StallCnt),  32'h0);
    check("rst_flushcnt", 32'(FlushCnt),  32'h0);

    tick();
    rstn = 1'b1;

    // Fill the pipeline
    InstValidF = 1'b1;
    ticks(4);
    #2;
    check("fill_valids", 32'(valids()), 32'hF);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    MemReadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
    #1;
    check("lu_ctrl", 32'(ctrl()), 32'b1100010);
    tick();
    #2;
    // EX now holds the bubble; dependency tags still present -> no 2nd bubble
    check("lu_valids",   32'(valids()), 32'b1011);
    check("lu_stallcnt", 32'(StallCnt), 32'd1);
    check("lu_one_bubble_ctrl", 32'(ctrl()), 32'h0);

    // Same pair with x0 as the destination: no stall
    MemReadE = 1'b0;
    tick();                         // valids -> 1101
    MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #2;
    check("x0_valids", 32'(valids()), 32'b1101);
    check("x0_ctrl",   32'(ctrl()),   32'h0);
    tick();
    #2;
    check("x0_stallcnt", 32'(StallCnt), 32'd1);
    check("x0_valids_adv", 32'(valids()), 32'b1110);
    MemReadE = 1'b0;

    // Redirect with a fetch in flight -> DROP
    BranchE = 1'b1; IfuBusy = 1'b1; InstValidF = 1'b0;
    #1;
    check("br_ctrl", 32'(ctrl()), 32'b0000110);
    tick();
    BranchE = 1'b0;
    #2;
    check("br_valids",   32'(valids()), 32'b0011);
    check("br_flushcnt", 32'(FlushCnt), 32'd1);
    check("br_nodrop_idle", 32'(ctrl()), 32'h0);
    InstValidF = 1'b1;
    #1;
    check("drop_ctrl", 32'(ctrl()), 32'b0000001);
    tick();
    IfuBusy = 1'b0;
    #2;
    check("drop_valids", 32'(valids()), 32'b0001);
    check("run_after_drop", 32'(ctrl()), 32'h0);
    check("drop_flushcnt", 32'(FlushCnt), 32'd1);

    // Refill: valids 1000 -> 1111
    ticks(4);
    #2;
    check("refill_valids", 32'(valids()), 32'hF);

    // Memory stall with a pending branch and a load-use in the shadow
    MemBusyM = 1'b1; BranchE = 1'b1; MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("ms_ctrl", 32'(ctrl()), 32'b1111000);
      tick();
      #1;
      check("ms_valids", 32'(valids()), 32'b1110);
    end
    MemBusyM = 1'b0;
    #1;
    check("ms_release_ctrl", 32'(ctrl()), 32'b0000110);
    tick();
    BranchE = 1'b0; MemReadE = 1'b0;
    #2;
    check("ms_release_valids", 32'(valids()), 32'b0011);
    check("ms_stallcnt", 32'(StallCnt), 32'd4);
    check("ms_flushcnt", 32'(FlushCnt), 32'd2);

    // Saturation: 11 more stall cycles reach 15, one more must hold
    InstValidF = 1'b0; MemBusyM = 1'b1;
    ticks(11);
    #2;
    check("sat_reach", 32'(StallCnt), 32'hF);
    check("sat_ctrl",  32'(ctrl()),   32'b1111000);
    tick();
    #2;
    check("sat_hold", 32'(StallCnt), 32'hF);

    // Asynchronous reset mid-cycle with a full pipeline
    MemBusyM = 1'b0; InstValidF = 1'b1;
    ticks(4);
    #2;
    check("pre_rst_valids", 32'(valids()), 32'hF);
    rstn = 1'b0;
    #1;
    check("async_rst_valids",   32'(valids()), 32'h0);
    check("async_rst_stallcnt", 32'(StallCnt), 32'h0);
    check("async_rst_flushcnt", 32'(FlushCnt), 32'h0);
    check("async_rst_ctrl",     32'(ctrl()),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_ysyx_23060184_pipe_ctrl
`default_nettype wire

// File: doc/ysyx_23060184_pipe_ctrl.md
Name: ysyx_23060184_pipe_ctrl

Overview:
- Pipeline stage-control unit for the 5-stage NPC core.
- Consumes the EX-stage redirect indication (Branch) and register tags from the forwarding/hazard logic, plus fetch and LSU handshakes.
- Owns per-stage valid bits and produces the stall/flush controls applied to the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers everything forwarding cannot resolve: load-use bubbles, redirect squash including an in-flight fetch, and multi-cycle memory stalls. Also keeps stall/flush performance counters.

Parameters:
REG_LENGTH, 5, register index width
CNT_WIDTH, 32, performance counter width

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
InstValidF  in  1  IFU returns an instruction this cycle
IfuBusy  in  1  IFU has a request outstanding
Rs1D  in  REG_LENGTH  source 1 index in ID
Rs2D  in  REG_LENGTH  source 2 index in ID
RdE  in  REG_LENGTH  destination index in EX
MemReadE  in  1  EX instruction is a load
BranchE  in  1  EX redirect (taken branch/jump)
MemBusyM  in  1  LSU not done with MEM access
StallF  out  1  hold PC / IF
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
DropF  out  1  discard current InstValidF response
ValidD  out  1  ID holds live instruction
ValidE  out  1  EX holds live instruction
ValidM  out  1  MEM holds live instruction
ValidW  out  1  WB holds live instruction
StallCnt  out  CNT_WIDTH  cycles with StallF asserted
FlushCnt  out  CNT_WIDTH  accepted redirects

Behaviour:
- Reset (rstn low, async): all Valid* = 0; state = RUN; counters = 0. All Stall*/Flush*/DropF = 0 while in reset.
- Event definitions:
  - memStall = MemBusyM & ValidM.
  - redirect = BranchE & ValidE & !memStall.
  - loadUse = MemReadE & ValidE & ValidD & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D) & !redirect & !memStall.
- Priority: memStall > redirect > loadUse.
- memStall:
  - StallF = StallD = StallE = StallM = 1.
  - ValidW <= 0 (bubble into WB); all other valids hold.
  - A BranchE raised during memStall is acted on in the first cycle memStall clears.
- redirect:
  - FlushD = FlushE = 1; next ValidD <= 0, ValidE <= 0.
  - ValidM <= 1 (the branch advances).
  - FlushCnt += 1.
  - If IfuBusy is 1 and InstValidF is 0 in the same cycle, go to state DROP.
- loadUse:
  - StallF = StallD = 1 and FlushE = 1; ValidE <= 0.
  - Exactly one bubble per dependency. The following cycle the load is in MEM and is covered by forwarding.
- Normal advance:
  - ValidD <= InstValidF & !DropF.
  - ValidE <= ValidD; ValidM <= ValidE; ValidW <= ValidM.
- FSM:
  - RUN: DropF = 0.
  - DROP: DropF = InstValidF. Exit to RUN on the cycle InstValidF = 1 (that response is discarded) or when IfuBusy drops.
  - A second redirect while in DROP remains in DROP.
- Stalls win over fetch: when StallD = 1, InstValidF is not consumed. The IFU holds its response until StallF deasserts.
- Counters:
  - StallCnt += 1 on each cycle StallF = 1; FlushCnt increments as above.
  - Both saturate at all-ones and never wrap.
- Rd index 0 never triggers loadUse.
- Stall/flush outputs are combinational from the current valids, state and inputs. Valids, state and counters are registered.

Decomposition:
- Shared defines header gains PIPE_STATE_RUN/PIPE_STATE_DROP encodings and the state width. REG_LENGTH reuses the existing header define.
- One sub-module is natural: ysyx_23060184_SatCounter (enable, saturating, CNT_WIDTH), instantiated twice.

Test Plan:
- Reset mid-run: valids 1111, assert rstn = 0 mid-cycle → all Valid* = 0 and counters = 0 immediately, without waiting for a clock edge.
- lw x5 then add x6,x5,x1 (RdE = 5, Rs1D = 5, MemReadE = 1) → one cycle of StallF = StallD = FlushE = 1, ValidE = 0 next cycle, StallCnt = 1.
- Same pair with RdE = 0 and Rs1D = 0 → no stall.
- BranchE = 1, ValidE = 1, IfuBusy = 1, InstValidF = 0 → FlushD = FlushE = 1, state DROP. Next InstValidF = 1 gives DropF = 1 and ValidD stays 0, then back to RUN; FlushCnt = 1.
- MemBusyM = 1 for 3 cycles with BranchE = 1 and a loadUse present:
  - During: all four Stall* = 1 and ValidW = 0, with no flush.
  - Cycle 4: redirect is taken and the load-use stall is suppressed.
- Force StallCnt to all-ones, then stall one more cycle → StallCnt remains all-ones.
